// File: rtl/regfile_write_port.sv
// Write side of the register file: in-order write queue, one commit per cycle.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_write_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2,
  localparam int NUM_REGS  = 2**ADDR_WIDTH,
  localparam int CNT_W     = $clog2(DEPTH+1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ready,
  input  logic                           commit_en,
  output logic [NUM_REGS-1:0]            commit_onehot,
  output logic [CNT_W-1:0]               pending,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  push;
  logic                  pop;
  logic                  store;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_REGS-1:0]   dec;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends on occupancy only; a full queue
  // refuses input even while it drains.
  assign wr_ready  = (count < CNT_W'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign pop       = commit_en && (count != '0);
  assign head_addr = q_addr[head];
  assign head_data = q_data[head];
  assign pending   = count;

`ifdef REGFILE_R0_ZERO_EN
  assign store = (head_addr != '0);
`else
  assign store = 1'b1;
`endif

  always_comb begin
    dec = '0;
    dec[head_addr] = store;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= wr_addr;
      q_data[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      commit_onehot <= '0;
    end else begin
      if (pop && store)
        regs[head_addr] <= head_data;
      commit_onehot <= pop ? dec : '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: vector table, hand sequences, random vs model.
// Honours REGFILE_R0_ZERO_EN in its expectations.
module tb_regfile_write_port;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 2;
  localparam int NR = 16;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_ready;
  logic            commit_en;
  logic [NR-1:0]   commit_onehot;
  logic [1:0]      pending;
  logic [NR*DW-1:0] regs_flat;

  regfile_write_port dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .commit_en(commit_en),
    .commit_onehot(commit_onehot),
    .pending(pending), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          cen;
    logic          rdy;
    int            pend;
    logic [NR-1:0] oh;
  } vec_t;

  ent_t          mq[$];
  logic [DW-1:0] mregs [NR];
  logic [NR-1:0] moh;
  int            tests = 0;
  int            failed = 0;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mflat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++)
      f[i*DW +: DW] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    moh = '0;
  endtask

  task automatic cycle(input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic cen);
    bit   rdy;
    bit   pop;
    ent_t e;
    wr_valid = v; wr_addr = a; wr_data = d; commit_en = cen;
    rdy = (mq.size() < DEPTH);
    #1;
    chk("wr_ready", 256'(wr_ready), 256'(rdy));
    @(posedge clk);
    pop = cen && (mq.size() > 0);
    moh = '0;
    if (pop) begin
      e = mq.pop_front();
      if (!(R0Z && e.addr == 0)) begin
        mregs[e.addr] = e.data;
        moh = NR'(1) << e.addr;
      end
    end
    if (v && rdy) begin
      e.addr = a; e.data = d;
      mq.push_back(e);
    end
    #1;
    chk("pending", 256'(pending), 256'(mq.size()));
    chk("onehot", 256'(commit_onehot), 256'(moh));
    chk("regs_flat", 256'(regs_flat), 256'(mflat()));
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return regs_flat[i*DW +: DW];
  endfunction

  vec_t tv[$];

  function automatic vec_t mk(logic v, int a, int d, logic cen,
                              logic rdy, int pend, int oh);
    vec_t t;
    t.v = v; t.a = AW'(a); t.d = DW'(d); t.cen = cen;
    t.rdy = rdy; t.pend = pend; t.oh = NR'(oh);
    return t;
  endfunction

  initial begin
    tv.push_back(mk(1, 3, 'hBEEF, 1, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0008));
    tv.push_back(mk(1, 1, 'h1111, 0, 1, 1, 0));
    tv.push_back(mk(1, 2, 'h2222, 0, 1, 2, 0));
    tv.push_back(mk(1, 4, 'h4444, 0, 0, 2, 0));
    tv.push_back(mk(1, 4, 'h4444, 1, 0, 1, 'h0002));
    tv.push_back(mk(1, 4, 'h4444, 1, 1, 1, 'h0004));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0010));
    tv.push_back(mk(1, 5, 'h0001, 1, 1, 1, 0));
    tv.push_back(mk(1, 5, 'h0002, 1, 1, 1, 'h0020));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 'h0020));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 6 + i, 'hA000 + i, 1, 1, 1,
                      (i == 0) ? 0 : (1 << (5 + i))));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, 1 << 13));
    tv.push_back(mk(1, 0, 'hFFFF, 1, 1, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 0, R0Z ? 0 : 1));

    rst = 1'b1; wr_valid = 0; wr_addr = '0;
    wr_data = '0; commit_en = 0;
    model_reset();
    #12;
    chk("rst_pending", 256'(pending), 256'(0));
    chk("rst_flat", 256'(regs_flat), 256'(0));
    chk("rst_onehot", 256'(commit_onehot), 256'(0));
    chk("rst_ready", 256'(wr_ready), 256'(1));
    rst = 1'b0;

    foreach (tv[k]) begin
      chk("tv_ready", 256'(wr_ready), 256'(tv[k].rdy));
      cycle(tv[k].v, tv[k].a, tv[k].d, tv[k].cen);
      chk("tv_pending", 256'(pending), 256'(tv[k].pend));
      chk("tv_onehot", 256'(commit_onehot), 256'(tv[k].oh));
    end
    chk("reg0", 256'(reg_of(0)), 256'(R0Z ? 16'h0 : 16'hFFFF));
    chk("reg1", 256'(reg_of(1)), 256'(16'h1111));
    chk("reg2", 256'(reg_of(2)), 256'(16'h2222));
    chk("reg3", 256'(reg_of(3)), 256'(16'hBEEF));
    chk("reg4", 256'(reg_of(4)), 256'(16'h4444));
    chk("reg5", 256'(reg_of(5)), 256'(16'h0002));
    for (int i = 0; i < 8; i++)
      chk("reg_stream", 256'(reg_of(6 + i)), 256'(16'hA000 + i));
    chk("reg14", 256'(reg_of(14)), 256'(0));

    // Two queued writes, then an async reset pulse between edges.
    cycle(1, 4'd7, 16'h7777, 0);
    cycle(1, 4'd8, 16'h8888, 0);
    chk("pre_rst_pending", 256'(pending), 256'(2));
    #2 rst = 1'b1;
    #1;
    chk("arst_pending", 256'(pending), 256'(0));
    chk("arst_flat", 256'(regs_flat), 256'(0));
    chk("arst_onehot", 256'(commit_onehot), 256'(0));
    chk("arst_ready", 256'(wr_ready), 256'(1));
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 4'd0, 16'h0, 1);
      chk("no_stale", 256'(commit_onehot), 256'(0));
    end

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), AW'($urandom),
            DW'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 3) != 0), AW'($urandom),
            DW'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 16 x 16-bit register file; pairs with the 16:1 read mux, which selects from the stored words.
- Accepts write requests over a valid/ready handshake and buffers them in a small in-order queue.
- Commits one queued write per cycle when allowed, decoding the 4-bit address to a one-hot enable.
- Presents all register contents as a flat bus to the read mux.

Parameters:
- DATA_WIDTH, 16: register word width.
- ADDR_WIDTH, 4: address width; NUM_REGS = 2**ADDR_WIDTH = 16.
- DEPTH, 2: write-queue entries; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- wr_valid  in  1  write request present.
- wr_addr  in  ADDR_WIDTH  target register.
- wr_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  queue can accept this cycle.
- commit_en  in  1  permit the head entry to commit this cycle.
- commit_onehot  out  NUM_REGS  one-hot of the register written at the last edge; 0 if none.
- pending  out  $clog2(DEPTH+1)  queued, uncommitted entry count.
- regs_flat  out  NUM_REGS*DATA_WIDTH  register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (async, rst=1):
  - Queue flushed; pending=0.
  - All registers 0, so regs_flat=0.
  - commit_onehot=0.
  - wr_ready=1 once reset is seen.
  - Reset mid-operation discards queued writes; no partial commit.
- wr_ready = (pending < DEPTH).
  - Combinational from pending only; it does not look ahead at a same-cycle commit.
  - A full queue refuses input even when it is committing in the same cycle.
- Accept: wr_valid && wr_ready at a rising edge pushes {wr_addr, wr_data} at the tail.
  - If wr_ready=0, wr_valid is ignored; the source holds its request.
- Commit: commit_en && pending>0 at a rising edge:
  - writes the head data into register[head addr];
  - pops the head;
  - loads commit_onehot with 1<<head addr.
  - Otherwise commit_onehot loads 0, so it is a single-cycle pulse per commit.
- Latency:
  - An entry accepted at edge N commits at edge N+1 at the earliest.
  - regs_flat reflects the new value after edge N+1.
  - There is no write-through from wr_data to regs_flat.
- Simultaneous accept and commit: pending is unchanged, the head advances and the new entry joins the tail.
- Ordering:
  - Strict FIFO.
  - Two writes to the same address commit in order; the later value persists.
- Queue pointers wrap modulo DEPTH; pending never exceeds DEPTH or underflows.
- commit_en with pending=0 has no effect.
- Unaddressed registers hold their value.
- regs_flat and commit_onehot are driven directly from flops.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - register 0 is hardwired to 0 and its slice of regs_flat is always 0;
  - writes to address 0 are accepted and committed (they pop the queue) but store nothing;
  - commit_onehot bit 0 stays 0.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset, then write addr=3 data=0xBEEF with commit_en=1.
  - wr_ready=1.
  - Next edge: pending=1.
  - Following edge: reg3=0xBEEF, commit_onehot=0x0008, pending=0.
  - All other registers remain 0.
- commit_en=0, then push addr=1 0x1111 and addr=2 0x2222.
  - pending=2, wr_ready=0.
  - A third request (addr=4 0x4444) is held and not accepted.
  - Raise commit_en: reg1=0x1111, then reg2=0x2222 on consecutive edges; the third request is accepted after the first pop.
- Back-to-back writes addr=5 0x0001 then addr=5 0x0002, commit_en=1.
  - commit_onehot=0x0020 on two consecutive cycles.
  - Final reg5=0x0002.
- Continuous stream of 8 writes with commit_en=1 every cycle.
  - pending stays at 1 in steady state and wr_ready stays 1.
  - All 8 registers are correct, confirming pointer wrap.
- Queue 2 entries with commit_en=0, then pulse rst asynchronously between edges.
  - Immediately: pending=0, regs_flat=0, commit_onehot=0.
  - After release, no stale commit occurs.
- With REGFILE_R0_ZERO_EN defined, write addr=0 0xFFFF.
  - pending returns to 0.
  - reg0 stays 0 and commit_onehot stays 0x0000.
  - Without the macro: reg0=0xFFFF and commit_onehot=0x0001.
